// File: rtl/softmax_vec_ram.sv
// softmax_vec_ram: multi-read-port vector memory with a lane-masked direct write
// port and a stream loader that packs scalar elements into vectors.
//
// Ports:
//   clk_i, rst_ni    - clock (rising edge), asynchronous active-low reset
//   rd_addr_i        - NRD read addresses, port p at [p*AWIDTH +: AWIDTH]
//   rd_data_o        - NRD read vectors, port p at [p*NUM*DWIDTH +: NUM*DWIDTH]
//   wr_en_i, wr_addr_i, wr_lane_en_i, wr_data_i - direct lane-masked write
//   ld_start_i, ld_base_i, ld_count_i           - loader start / base / vector count
//   ld_valid_i, ld_data_i, ld_ready_o           - scalar element stream
//   ld_busy_o, ld_done_o                        - loader status
//   wr_drop_o        - sticky: a direct write arrived while the loader was busy
module softmax_vec_ram #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned NUM    = 4,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned NRD    = 3,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NRD*AWIDTH-1:0]      rd_addr_i,
  output logic [NRD*NUM*DWIDTH-1:0]  rd_data_o,
  input  logic                       wr_en_i,
  input  logic [AWIDTH-1:0]          wr_addr_i,
  input  logic [NUM-1:0]             wr_lane_en_i,
  input  logic [NUM*DWIDTH-1:0]      wr_data_i,
  input  logic                       ld_start_i,
  input  logic [AWIDTH-1:0]          ld_base_i,
  input  logic [AWIDTH:0]            ld_count_i,
  input  logic                       ld_valid_i,
  input  logic [DWIDTH-1:0]          ld_data_i,
  output logic                       ld_ready_o,
  output logic                       ld_busy_o,
  output logic                       ld_done_o,
  output logic                       wr_drop_o
);

  localparam int unsigned VecW  = NUM * DWIDTH;
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LaneW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [AWIDTH:0] DepthLim = (AWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  function automatic logic in_range(input logic [AWIDTH-1:0] a);
    return {1'b0, a} < DepthLim;
  endfunction

  // Storage is intentionally not reset.
  logic [VecW-1:0] mem_q [DEPTH];

  state_e             state_q;
  logic [AWIDTH-1:0]  base_q;
  logic [AWIDTH:0]    count_q;
  logic [AWIDTH:0]    k_q;
  logic [LaneW-1:0]   lane_q;
  logic [VecW-1:0]    vec_q;
  logic               wr_drop_q;

  logic               hs;
  logic               last_lane;
  logic [VecW-1:0]    vec_full;
  logic [AWIDTH-1:0]  ld_addr;

  logic               mem_we;
  logic [AWIDTH-1:0]  mem_addr;
  logic [NUM-1:0]     mem_lane_en;
  logic [VecW-1:0]    mem_wdata;

  assign ld_ready_o = (state_q == StLoad);
  assign ld_busy_o  = (state_q == StLoad);
  assign ld_done_o  = (state_q == StDone);
  assign wr_drop_o  = wr_drop_q;

  assign hs        = ld_valid_i && (state_q == StLoad);
  assign last_lane = (lane_q == LaneW'(NUM - 1));
  // Address wraps modulo 2^AWIDTH by truncation.
  assign ld_addr   = base_q + k_q[AWIDTH-1:0];

  // Accumulated vector including the element arriving this cycle, so the last
  // lane can be committed on the same edge it is accepted.
  always_comb begin
    vec_full = vec_q;
    vec_full[32'(lane_q) * DWIDTH +: DWIDTH] = ld_data_i;
  end

  // Single memory write port shared by the loader and the direct port; the
  // direct port is locked out while loading, so they never collide.
  always_comb begin
    mem_we      = 1'b0;
    mem_addr    = wr_addr_i;
    mem_lane_en = wr_lane_en_i;
    mem_wdata   = wr_data_i;
    if (state_q == StLoad) begin
      if (hs && last_lane) begin
        mem_we      = in_range(ld_addr);
        mem_addr    = ld_addr;
        mem_lane_en = '1;
        mem_wdata   = vec_full;
      end
    end else if (wr_en_i) begin
      mem_we = in_range(wr_addr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int l = 0; l < NUM; l++) begin
        if (mem_lane_en[l]) begin
          mem_q[mem_addr[IdxW-1:0]][l*DWIDTH +: DWIDTH] <= mem_wdata[l*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  // Loader FSM and sticky drop flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      base_q    <= '0;
      count_q   <= '0;
      k_q       <= '0;
      lane_q    <= '0;
      vec_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      if (ld_busy_o && wr_en_i) begin
        wr_drop_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (ld_start_i) begin
            base_q  <= ld_base_i;
            count_q <= ld_count_i;
            k_q     <= '0;
            lane_q  <= '0;
            state_q <= (ld_count_i == '0) ? StDone : StLoad;
          end
        end
        StLoad: begin
          if (hs) begin
            vec_q <= vec_full;
            if (last_lane) begin
              lane_q <= '0;
              k_q    <= k_q + (AWIDTH + 1)'(1);
              if (k_q == count_q - (AWIDTH + 1)'(1)) begin
                state_q <= StDone;
              end
            end else begin
              lane_q <= lane_q + LaneW'(1);
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read ports.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AWIDTH-1:0] addr;
    logic [VecW-1:0]   rdata;
    assign addr  = rd_addr_i[p*AWIDTH +: AWIDTH];
    assign rdata = in_range(addr) ? mem_q[addr[IdxW-1:0]] : '0;
    if (RD_LAT == 0) begin : g_comb
      assign rd_data_o[p*VecW +: VecW] = rdata;
    end else begin : g_reg
      logic [VecW-1:0] rd_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_q <= '0;
        end else begin
          rd_q <= rdata;
        end
      end
      assign rd_data_o[p*VecW +: VecW] = rd_q;
    end
  end

endmodule

// File: tb/tb_softmax_vec_ram.sv
// tb_softmax_vec_ram: directed self-checking bench for softmax_vec_ram
// (RD_LAT=1, AWIDTH=9, DEPTH=256, NUM=4, DWIDTH=16, NRD=3).
module tb_softmax_vec_ram;
  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int AW  = 9;
  localparam int DEP = 256;
  localparam int NR  = 3;
  localparam int VW  = N * DW;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*VW-1:0]  rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [N-1:0]      wr_lane_en;
  logic [VW-1:0]     wr_data;
  logic              ld_start;
  logic [AW-1:0]     ld_base;
  logic [AW:0]       ld_count;
  logic              ld_valid;
  logic [DW-1:0]     ld_data;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              wr_drop;

  int checks;
  int failures;

  softmax_vec_ram #(
    .DWIDTH(DW), .NUM(N), .AWIDTH(AW), .DEPTH(DEP), .NRD(NR), .RD_LAT(1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_lane_en_i(wr_lane_en),
    .wr_data_i   (wr_data),
    .ld_start_i  (ld_start),
    .ld_base_i   (ld_base),
    .ld_count_i  (ld_count),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_ready_o  (ld_ready),
    .ld_busy_o   (ld_busy),
    .ld_done_o   (ld_done),
    .wr_drop_o   (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dwrite(input logic [AW-1:0] a, input logic [N-1:0] m, input logic [VW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_lane_en = m; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read3(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       output logic [VW-1:0] d0, output logic [VW-1:0] d1,
                       output logic [VW-1:0] d2);
    rd_addr = {a2, a1, a0};
    tick();
    d0 = rd_data[0*VW +: VW];
    d1 = rd_data[1*VW +: VW];
    d2 = rd_data[2*VW +: VW];
  endtask

  // Starts a load and streams nelem elements first, first+1, ...; returns the
  // cycle (counting the start edge as edge 0) in which ld_done is seen, or -1.
  task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] cnt, input bit toggle,
                          input int nelem, input logic [DW-1:0] first, output int done_cyc);
    int elem;
    ld_start = 1'b1; ld_base = base; ld_count = cnt;
    tick();
    ld_start = 1'b0;
    elem = 0;
    done_cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      ld_valid = (elem < nelem) && (!toggle || (c % 2 == 0));
      ld_data  = first + DW'(elem);
      if (ld_valid && ld_ready) elem++;
      tick();
      if (ld_done) begin
        done_cyc = c + 1;
        break;
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL reset_ld_busy got=%b exp=0", ld_busy); end
    checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL reset_ld_done got=%b exp=0", ld_done); end
    checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    #9;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_direct_write();
    logic [VW-1:0] d0, d1, d2;
    rd_addr = {9'd5, 9'd300, 9'd5};
    dwrite(9'd5, 4'b1111, 64'h0004_0003_0002_0001);
    read3(9'd5, 9'd300, 9'd5, d0, d1, d2);
    checks++; if (d0 !== 64'h0004_0003_0002_0001) begin failures++; $display("FAIL dwrite_p0 got=%h exp=%h", d0, 64'h0004_0003_0002_0001); end
    checks++; if (d1 !== 64'h0) begin failures++; $display("FAIL oob_read_p1 got=%h exp=0", d1); end
    checks++; if (d2 !== 64'h0004_0003_0002_0001) begin failures++; $display("FAIL dwrite_p2 got=%h exp=%h", d2, 64'h0004_0003_0002_0001); end
  endtask

  task automatic test_masked_write();
    logic [VW-1:0] d0, d1, d2;
    dwrite(9'd5, 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF);
    // Out-of-range write must neither store nor flag.
    dwrite(9'd300, 4'b1111, 64'h1234_1234_1234_1234);
    read3(9'd5, 9'd300, 9'd5, d0, d1, d2);
    checks++; if (d0 !== 64'h0004_FFFF_0002_FFFF) begin failures++; $display("FAIL masked_write got=%h exp=%h", d0, 64'h0004_FFFF_0002_FFFF); end
    checks++; if (d1 !== 64'h0) begin failures++; $display("FAIL oob_write got=%h exp=0", d1); end
    checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL oob_no_flag got=%b exp=0", wr_drop); end
  endtask

  task automatic test_load_cont();
    int dc;
    logic [VW-1:0] d0, d1, d2;
    run_load(9'd2, 10'd3, 1'b0, 12, 16'h0010, dc);
    checks++; if (dc !== 13) begin failures++; $display("FAIL cont_done_cycle got=%0d exp=13", dc); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL cont_ready_at_done got=%b exp=0", ld_ready); end
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL cont_busy_at_done got=%b exp=0", ld_busy); end
    tick();
    checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL cont_done_pulse got=%b exp=0", ld_done); end
    read3(9'd2, 9'd3, 9'd4, d0, d1, d2);
    checks++; if (d0 !== 64'h0013_0012_0011_0010) begin failures++; $display("FAIL cont_addr2 got=%h exp=%h", d0, 64'h0013_0012_0011_0010); end
    checks++; if (d1 !== 64'h0017_0016_0015_0014) begin failures++; $display("FAIL cont_addr3 got=%h exp=%h", d1, 64'h0017_0016_0015_0014); end
    checks++; if (d2 !== 64'h001B_001A_0019_0018) begin failures++; $display("FAIL cont_addr4 got=%h exp=%h", d2, 64'h001B_001A_0019_0018); end
  endtask

  task automatic test_load_stall();
    int dc;
    logic [VW-1:0] d0, d1, d2;
    dwrite(9'd2, 4'b1111, 64'h0);
    dwrite(9'd3, 4'b1111, 64'h0);
    dwrite(9'd4, 4'b1111, 64'h0);
    run_load(9'd2, 10'd3, 1'b1, 12, 16'h0010, dc);
    checks++; if (dc !== 25) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=25", dc); end
    tick();
    read3(9'd2, 9'd3, 9'd4, d0, d1, d2);
    checks++; if (d0 !== 64'h0013_0012_0011_0010) begin failures++; $display("FAIL stall_addr2 got=%h exp=%h", d0, 64'h0013_0012_0011_0010); end
    checks++; if (d1 !== 64'h0017_0016_0015_0014) begin failures++; $display("FAIL stall_addr3 got=%h exp=%h", d1, 64'h0017_0016_0015_0014); end
    checks++; if (d2 !== 64'h001B_001A_0019_0018) begin failures++; $display("FAIL stall_addr4 got=%h exp=%h", d2, 64'h001B_001A_0019_0018); end
  endtask

  task automatic test_write_during_load();
    logic [VW-1:0] d0, d1, d2;
    dwrite(9'd10, 4'b1111, 64'hAAAA_AAAA_AAAA_AAAA);
    ld_start = 1'b1; ld_base = 9'd20; ld_count = 10'd1;
    tick();
    // Cycle 1: in LOAD; collide a direct write and a new start with the first element.
    checks++; if (ld_busy !== 1'b1) begin failures++; $display("FAIL wdl_busy got=%b exp=1", ld_busy); end
    ld_start = 1'b1; ld_base = 9'd30; ld_count = 10'd5;
    wr_en = 1'b1; wr_addr = 9'd10; wr_lane_en = 4'b1111; wr_data = 64'h5555_5555_5555_5555;
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 16'h0040 + 16'(i);
      tick();
      wr_en = 1'b0;
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL wdl_start_ignored_done got=%b exp=1", ld_done); end
    checks++; if (wr_drop !== 1'b1) begin failures++; $display("FAIL wdl_wr_drop got=%b exp=1", wr_drop); end
    tick();
    read3(9'd10, 9'd20, 9'd10, d0, d1, d2);
    checks++; if (d0 !== 64'hAAAA_AAAA_AAAA_AAAA) begin failures++; $display("FAIL wdl_target_kept got=%h exp=%h", d0, 64'hAAAA_AAAA_AAAA_AAAA); end
    checks++; if (d1 !== 64'h0043_0042_0041_0040) begin failures++; $display("FAIL wdl_loaded got=%h exp=%h", d1, 64'h0043_0042_0041_0040); end
    tick();
    tick();
    checks++; if (wr_drop !== 1'b1) begin failures++; $display("FAIL wdl_wr_drop_sticky got=%b exp=1", wr_drop); end
  endtask

  task automatic test_reset_midload();
    int dc;
    logic [VW-1:0] d0, d1, d2;
    dwrite(9'd51, 4'b1111, 64'h2222_2222_2222_2222);
    rd_addr = {9'd5, 9'd5, 9'd5};
    ld_start = 1'b1; ld_base = 9'd50; ld_count = 10'd2;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_data = 16'h0060 + 16'(i);
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL rml_busy got=%b exp=0", ld_busy); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rml_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL rml_done got=%b exp=0", ld_done); end
    checks++; if (wr_drop !== 1'b0) begin failures++; $display("FAIL rml_wr_drop got=%b exp=0", wr_drop); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL rml_rd_data got=%h exp=0", rd_data); end
    #1;
    rst_n = 1'b1;
    tick();
    // A fresh load must start at lane 0 despite the discarded partial vector.
    run_load(9'd52, 10'd1, 1'b0, 4, 16'h0070, dc);
    checks++; if (dc !== 5) begin failures++; $display("FAIL rml_new_done_cycle got=%0d exp=5", dc); end
    tick();
    read3(9'd50, 9'd51, 9'd52, d0, d1, d2);
    checks++; if (d0 !== 64'h0063_0062_0061_0060) begin failures++; $display("FAIL rml_vec0 got=%h exp=%h", d0, 64'h0063_0062_0061_0060); end
    checks++; if (d1 !== 64'h2222_2222_2222_2222) begin failures++; $display("FAIL rml_vec1 got=%h exp=%h", d1, 64'h2222_2222_2222_2222); end
    checks++; if (d2 !== 64'h0073_0072_0071_0070) begin failures++; $display("FAIL rml_fresh got=%h exp=%h", d2, 64'h0073_0072_0071_0070); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_lane_en = '0; wr_data = '0;
    ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_valid = 1'b0; ld_data = '0;
    test_reset();
    test_direct_write();
    test_masked_write();
    test_load_cont();
    test_load_stall();
    test_write_during_load();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_vec_ram.md
# softmax_vec_ram

Parametrised vector memory for the softmax datapath: `NRD` independent read ports, each returning one `NUM`-lane vector of `DWIDTH`-bit elements, plus a lane-masked direct write port. A built-in stream loader packs scalar elements arriving on a valid/ready interface into vectors and writes them at consecutive addresses. It replaces the single-port, combinational-read, write-only-from-file memory model. It lets benches and the top level preload operand and subtraction tables through RTL instead of `$readmemh`.

## Interface
- `DWIDTH`, 16, element width in bits
- `NUM`, 4, lanes per vector (≥1)
- `AWIDTH`, 8, address width
- `DEPTH`, 256, number of vectors stored (1..2^AWIDTH)
- `NRD`, 3, number of read ports
- `RD_LAT`, 1, read latency: 0 = combinational, 1 = registered
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low
- `rd_addr` in NRD*AWIDTH: read addresses, port p at bits [p*AWIDTH +: AWIDTH]
- `rd_data` out NRD*NUM*DWIDTH: read vectors, port p at [p*NUM*DWIDTH +: NUM*DWIDTH], lane 0 in the LSBs
- `wr_en` in 1: direct write strobe
- `wr_addr` in AWIDTH: direct write address
- `wr_lane_en` in NUM: per-lane write mask
- `wr_data` in NUM*DWIDTH: direct write vector
- `ld_start` in 1: start-load pulse
- `ld_base` in AWIDTH: first vector address
- `ld_count` in AWIDTH+1: number of vectors to load
- `ld_valid` in 1: stream element valid
- `ld_data` in DWIDTH: stream element
- `ld_ready` out 1: loader accepts an element
- `ld_busy` out 1: load in progress
- `ld_done` out 1: one-cycle pulse at load completion
- `wr_drop` out 1: sticky flag, a direct write was discarded

## Operation
- Storage is `DEPTH` × `NUM*DWIDTH` bits. Contents are not cleared by reset.
- Reads:
  - An address ≥ `DEPTH` returns all zeros.
  - Ports are fully independent. Identical addresses on several ports are legal.
- Direct write: on `wr_en`, each lane l with `wr_lane_en[l]`=1 is written with its lane of `wr_data`. Masked lanes keep their value.
  - Address ≥ `DEPTH`: no write and no flag.
- Loader FSM has three states: IDLE, LOAD, DONE.
  - IDLE: `ld_start`=1 latches `ld_base` and `ld_count`, then clears the lane counter and vector counter k.
    - `ld_count`=0 goes to DONE with no writes.
    - Otherwise it goes to LOAD.
  - LOAD: `ld_ready`=1 and `ld_busy`=1.
    - Each handshake (`ld_valid`&`ld_ready`) places `ld_data` in lane `lane_cnt`, starting at lane 0.
    - On the NUM-th handshake, the full vector (including the element from that cycle) is written at address (base+k) mod 2^AWIDTH in the same edge. Then k increments and the lane counter clears.
    - If the computed address is ≥ `DEPTH`, the write is dropped silently and k still advances.
    - After vector `ld_count`-1 is committed, go to DONE.
  - DONE: `ld_done`=1 for exactly one cycle, then go to IDLE. `ld_busy`=0.
  - `ld_start` is ignored in LOAD and DONE.
- Write arbitration:
  - While `ld_busy`=1, `wr_en` is ignored and sets `wr_drop`.
  - `wr_drop` is cleared only by reset.
  - In IDLE and DONE, direct writes proceed normally.
- Reset asserted mid-load: the FSM returns to IDLE and the partial vector is discarded. Vectors already committed stay in memory.

## Timing
- Reset values: `rd_data` (RD_LAT=1) = 0, `ld_ready`=0, `ld_busy`=0, `ld_done`=0, `wr_drop`=0, FSM=IDLE.
- RD_LAT=0:
  - `rd_data` follows `rd_addr` combinationally.
  - A read of a location being written in the current cycle shows the old data until the edge.
- RD_LAT=1:
  - `rd_data` is registered, so data for the address presented in cycle n appears in cycle n+1.
  - Read-during-write returns the old data (read-first).
- Memory writes take effect at the rising edge. They are visible on a combinational read one cycle later and on a registered read two cycles later.
- Load latency:
  - `ld_start` at edge 0 sets `ld_ready`=1 from cycle 1.
  - With `ld_valid` held high, vector j is committed at edge (j+1)*NUM.
  - `ld_done` is high in cycle `ld_count`*NUM+1.
  - `ld_ready` drops in that same cycle.
- Stalls (`ld_valid`=0) extend the load one cycle each and do not alter lane order.

## Test plan
- Reset, then RD_LAT=1, direct write 0x0004_0003_0002_0001 at addr 5 with mask 4'b1111, read on port 0 → 0x0004_0003_0002_0001 two cycles after the write. Read port 1 at addr 300 (≥DEPTH, with AWIDTH=9) → 0.
- Masked write of 0xFFFF_FFFF_FFFF_FFFF with mask 4'b0101 at addr 5 → readback 0x0004_FFFF_0002_FFFF.
- Load with `ld_base`=2, `ld_count`=3, elements 0x10..0x1B streamed continuously:
  - addr 2 = 0x0013_0012_0011_0010, addr 4 = 0x001B_001A_0019_0018.
  - `ld_done` pulses in cycle 13.
- Same load with `ld_valid` toggled 1/0 each cycle → identical contents, `ld_done` 12 cycles later than the continuous case.
- `wr_en` during LOAD → target location unchanged, `wr_drop`=1 until reset. `ld_start` during LOAD → ignored.
- Reset asserted after 6 elements of a `ld_count`=2 load → vector 0 retained, vector 1 location unchanged. All outputs return to their reset values asynchronously.
